// File: rtl/axi_lite_reg_bridge_pkg.sv
// ============================================================================
//  Module      : axi_lite_reg_bridge_pkg
//  Description : Shared AXI-Lite types and response codes.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package axi_lite_reg_bridge_pkg;

    typedef logic [1:0] resp_t;
    typedef logic [2:0] prot_t;

    localparam resp_t RESP_OKAY   = 2'b00;
    localparam resp_t RESP_SLVERR = 2'b10;
    localparam resp_t RESP_DECERR = 2'b11;

endpackage

`default_nettype wire

// File: rtl/axi_lite_channel.sv
// ============================================================================
//  Module      : axi_lite_channel
//  Description : AXI-Lite bundle with master and slave views.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface axi_lite_channel
    import axi_lite_reg_bridge_pkg::*;
#(
    parameter int ADDR_WIDTH = 48,
    parameter int DATA_WIDTH = 64
);
    localparam int STRB_WIDTH = DATA_WIDTH / 8;

    logic                  clk;
    logic                  rstn;
    logic                  aw_valid;
    logic                  aw_ready;
    logic [ADDR_WIDTH-1:0] aw_addr;
    prot_t                 aw_prot;
    logic                  w_valid;
    logic                  w_ready;
    logic [DATA_WIDTH-1:0] w_data;
    logic [STRB_WIDTH-1:0] w_strb;
    logic                  b_valid;
    logic                  b_ready;
    resp_t                 b_resp;
    logic                  ar_valid;
    logic                  ar_ready;
    logic [ADDR_WIDTH-1:0] ar_addr;
    prot_t                 ar_prot;
    logic                  r_valid;
    logic                  r_ready;
    logic [DATA_WIDTH-1:0] r_data;
    resp_t                 r_resp;

    modport master (
        input  clk, rstn,
        output aw_valid, aw_addr, aw_prot, w_valid, w_data, w_strb, b_ready,
        output ar_valid, ar_addr, ar_prot, r_ready,
        input  aw_ready, w_ready, b_valid, b_resp, ar_ready, r_valid, r_data, r_resp
    );

    modport slave (
        input  clk, rstn,
        input  aw_valid, aw_addr, aw_prot, w_valid, w_data, w_strb, b_ready,
        input  ar_valid, ar_addr, ar_prot, r_ready,
        output aw_ready, w_ready, b_valid, b_resp, ar_ready, r_valid, r_data, r_resp
    );

endinterface

`default_nettype wire

// File: rtl/axi_lite_reg_bridge.sv
// ============================================================================
//  Module      : axi_lite_reg_bridge
//  Description : AXI-Lite slave to single-outstanding req/ack register bus,
//                with read/write round-robin, window decode and ack timeout.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module axi_lite_reg_bridge
    import axi_lite_reg_bridge_pkg::*;
#(
    parameter int                    ADDR_WIDTH = 48,
    parameter int                    DATA_WIDTH = 64,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0,
    parameter logic [ADDR_WIDTH-1:0] SIZE       = 'h1000,
    parameter int                    TIMEOUT    = 255
) (
    input  logic                    clk,
    input  logic                    rst,
    axi_lite_channel.slave          master,
    output logic                    reg_req,
    output logic                    reg_write,
    output logic [ADDR_WIDTH-1:0]   reg_addr,
    output logic [DATA_WIDTH-1:0]   reg_wdata,
    output logic [DATA_WIDTH/8-1:0] reg_wstrb,
    input  logic                    reg_ack,
    input  logic [DATA_WIDTH-1:0]   reg_rdata,
    input  logic                    reg_err
);
    localparam int                    STRB_WIDTH = DATA_WIDTH / 8;
    localparam int                    CNT_W      = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [ADDR_WIDTH-1:0] ADDR_MASK  = ~(ADDR_WIDTH'(STRB_WIDTH - 1));

    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_RESP} state_t;

    if ($bits(master.aw_addr) != ADDR_WIDTH) begin : g_addr_width_check
        $fatal(1, "axi_lite_reg_bridge: ADDR_WIDTH differs from master port");
    end
    if ($bits(master.w_data) != DATA_WIDTH) begin : g_data_width_check
        $fatal(1, "axi_lite_reg_bridge: DATA_WIDTH differs from master port");
    end

    state_t                r_state, w_state_next;
    logic                  r_prio_wr, r_is_write, r_req, r_bvalid, r_rvalid;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [DATA_WIDTH-1:0] r_wdata, r_rdata;
    logic [STRB_WIDTH-1:0] r_wstrb;
    resp_t                 r_resp;
    logic [CNT_W-1:0]      r_cnt;

    logic                  w_wr_cand, w_rd_cand, w_idle;
    logic                  w_grant_wr, w_grant_rd, w_grant, w_in_win;
    logic                  w_ack, w_timeout, w_resp_hs;
    logic [ADDR_WIDTH-1:0] w_offset;

    assign w_wr_cand  = master.aw_valid & master.w_valid;
    assign w_rd_cand  = master.ar_valid;
    // Readies stay low while reset is held even though the FSM already sits in IDLE.
    assign w_idle     = (r_state == S_IDLE) & ~rst;
    assign w_grant_wr = w_idle & w_wr_cand & (~w_rd_cand | r_prio_wr);
    assign w_grant_rd = w_idle & w_rd_cand & ~w_grant_wr;
    assign w_grant    = w_grant_wr | w_grant_rd;
    assign w_offset   = (w_grant_wr ? master.aw_addr : master.ar_addr) - BASE_ADDR;
    assign w_in_win   = (w_offset < SIZE);
    assign w_ack      = r_req & reg_ack;
    assign w_timeout  = (TIMEOUT != 0) && (r_state == S_BUSY) && !reg_ack
                        && (r_cnt == CNT_W'(TIMEOUT - 1));
    assign w_resp_hs  = (r_state == S_RESP) &&
                        (r_is_write ? (master.b_ready & r_bvalid) : (master.r_ready & r_rvalid));

    always_comb begin
        w_state_next    = r_state;
        master.aw_ready = w_grant_wr;
        master.w_ready  = w_grant_wr;
        master.ar_ready = w_grant_rd;
        case (r_state)
            S_IDLE:  if (w_grant) w_state_next = w_in_win ? S_BUSY : S_RESP;
            S_BUSY:  if (w_ack || w_timeout) w_state_next = S_RESP;
            S_RESP:  if (w_resp_hs) w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_next;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_prio_wr  <= 1'b1;
            r_is_write <= 1'b0;
            r_req      <= 1'b0;
            r_bvalid   <= 1'b0;
            r_rvalid   <= 1'b0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_wstrb    <= '0;
            r_rdata    <= '0;
            r_resp     <= RESP_OKAY;
            r_cnt      <= '0;
        end else begin
            case (r_state)
                S_IDLE: if (w_grant) begin
                    r_is_write <= w_grant_wr;
                    r_addr     <= w_offset & ADDR_MASK;
                    r_wdata    <= w_grant_wr ? master.w_data : '0;
                    r_wstrb    <= w_grant_wr ? master.w_strb : '0;
                    r_req      <= w_in_win;
                    r_cnt      <= '0;
                    if (!w_in_win) begin
                        r_resp   <= RESP_DECERR;
                        r_rdata  <= '0;
                        r_bvalid <= w_grant_wr;
                        r_rvalid <= w_grant_rd;
                    end
                    if (w_wr_cand && w_rd_cand) r_prio_wr <= ~w_grant_wr;
                end
                S_BUSY: begin
                    if (r_cnt != '1) r_cnt <= r_cnt + CNT_W'(1);
                    if (w_ack) begin
                        r_req    <= 1'b0;
                        r_rdata  <= r_is_write ? '0 : reg_rdata;
                        r_resp   <= reg_err ? RESP_SLVERR : RESP_OKAY;
                        r_bvalid <= r_is_write;
                        r_rvalid <= ~r_is_write;
                    end else if (w_timeout) begin
                        r_req    <= 1'b0;
                        r_rdata  <= '0;
                        r_resp   <= RESP_SLVERR;
                        r_bvalid <= r_is_write;
                        r_rvalid <= ~r_is_write;
                    end
                end
                S_RESP: if (w_resp_hs) begin
                    r_bvalid <= 1'b0;
                    r_rvalid <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign master.b_valid = r_bvalid;
    assign master.b_resp  = r_resp;
    assign master.r_valid = r_rvalid;
    assign master.r_resp  = r_resp;
    assign master.r_data  = r_rdata;
    assign reg_req        = r_req;
    assign reg_write      = r_is_write;
    assign reg_addr       = r_addr;
    assign reg_wdata      = r_wdata;
    assign reg_wstrb      = r_wstrb;

endmodule

`default_nettype wire
